// File: rtl/ht_res_sink.sv
// Result-stream sink: valid/ready intake into a FWFT buffer, plus saturating per-rescode counters.
// Define HT_RES_SINK_THROTTLE_EN to gate res_ready_o with an LFSR for pseudo-random backpressure.
module ht_res_sink #(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 16,
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       res_valid_i,
    output logic                       res_ready_o,
    input  logic [KEY_WIDTH-1:0]       res_key_i,
    input  logic [VALUE_WIDTH-1:0]     res_value_i,
    input  logic [1:0]                 res_opcode_i,
    input  logic [2:0]                 res_rescode_i,
    input  logic                       rd_en_i,
    output logic                       rd_valid_o,
    output logic [KEY_WIDTH-1:0]       rd_key_o,
    output logic [VALUE_WIDTH-1:0]     rd_value_o,
    output logic [1:0]                 rd_opcode_o,
    output logic [2:0]                 rd_rescode_o,
    output logic [$clog2(DEPTH):0]     used_o,
    input  logic [2:0]                 cnt_sel_i,
    output logic [CNT_WIDTH-1:0]       cnt_o,
    input  logic                       clear_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;
    localparam int EW = KEY_WIDTH + VALUE_WIDTH + 5;

    typedef logic [EW-1:0] entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]        used_q, used_d;
    logic [CNT_WIDTH-1:0] cnt_q [8];
    logic [CNT_WIDTH-1:0] cnt_d [8];
    logic                 full;
    logic                 gate;
    logic                 accept;
    logic                 pop;

`ifdef HT_RES_SINK_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Taps 16,14,13,11 (bits 15,13,12,10); shifts left every cycle outside reset.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        gate   = (lfsr_q[1:0] != 2'b00);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign gate = 1'b1;
`endif

    // Handshake: a result transfers on a rising edge where res_valid_i and res_ready_o are both
    // high; ready comes only from registered state and rst_i, never from res_valid_i.
    always_comb begin
        full        = (used_q == UW'(DEPTH));
        res_ready_o = !rst_i && !full && gate;
        accept      = res_valid_i && res_ready_o;
        pop         = rd_en_i && (used_q != '0);

        mem_d = mem_q;
        if (accept) mem_d[wr_ptr_q] = {res_key_i, res_value_i, res_opcode_i, res_rescode_i};

        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        used_d   = used_q + UW'(accept) - UW'(pop);

        // Clear first, so a simultaneous accept leaves its counter at exactly one.
        for (int i = 0; i < 8; i++) cnt_d[i] = clear_i ? '0 : cnt_q[i];
        if (accept && (cnt_d[res_rescode_i] != '1))
            cnt_d[res_rescode_i] = cnt_d[res_rescode_i] + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Storage needs no reset: rd_valid_o masks stale entries.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    assign {rd_key_o, rd_value_o, rd_opcode_o, rd_rescode_o} = mem_q[rd_ptr_q];
    assign rd_valid_o = (used_q != '0);
    assign used_o     = used_q;
    assign cnt_o      = cnt_q[cnt_sel_i];

endmodule

// File: tb/tb_ht_res_sink.sv
// Bench for ht_res_sink: queue/array reference model checked every cycle, plus directed literal checks.
module tb_ht_res_sink;
    localparam int KW    = 32;
    localparam int VW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int UW    = $clog2(DEPTH) + 1;
    localparam int EW    = KW + VW + 5;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          res_valid_i = 1'b0;
    logic          res_ready_o;
    logic [KW-1:0] res_key_i = '0;
    logic [VW-1:0] res_value_i = '0;
    logic [1:0]    res_opcode_i = '0;
    logic [2:0]    res_rescode_i = '0;
    logic          rd_en_i = 1'b0;
    logic          rd_valid_o;
    logic [KW-1:0] rd_key_o;
    logic [VW-1:0] rd_value_o;
    logic [1:0]    rd_opcode_o;
    logic [2:0]    rd_rescode_o;
    logic [UW-1:0] used_o;
    logic [2:0]    cnt_sel_i = '0;
    logic [CW-1:0] cnt_o;
    logic          clear_i = 1'b0;

    ht_res_sink #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_key_i(res_key_i), .res_value_i(res_value_i),
        .res_opcode_i(res_opcode_i), .res_rescode_i(res_rescode_i),
        .rd_en_i(rd_en_i), .rd_valid_o(rd_valid_o),
        .rd_key_o(rd_key_o), .rd_value_o(rd_value_o),
        .rd_opcode_o(rd_opcode_o), .rd_rescode_o(rd_rescode_o),
        .used_o(used_o), .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o), .clear_i(clear_i)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    logic [EW-1:0] exp_q[$];
    logic [CW-1:0] m_cnt [8];
    logic [15:0]   m_lfsr = 16'hACE1;
    bit            m_accept = 1'b0;
    bit            chk_en = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;

    function automatic bit model_ready();
        bit r;
        r = !rst_i && (exp_q.size() != DEPTH);
`ifdef HT_RES_SINK_THROTTLE_EN
        r = r && (m_lfsr[1:0] != 2'b00);
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_accept = res_valid_i && model_ready();
        if (rst_i) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) m_cnt[i] = '0;
            m_lfsr   = 16'hACE1;
            m_accept = 1'b0;
        end else begin
            if (clear_i) for (int i = 0; i < 8; i++) m_cnt[i] = '0;
            if (rd_en_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_accept) begin
                exp_q.push_back({res_key_i, res_value_i, res_opcode_i, res_rescode_i});
                if (m_cnt[res_rescode_i] != {CW{1'b1}}) m_cnt[res_rescode_i] = m_cnt[res_rescode_i] + 1;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", res_ready_o, model_ready());
            check("used", used_o, exp_q.size());
            check("rd_valid", rd_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0)
                check("head", {rd_key_o, rd_value_o, rd_opcode_o, rd_rescode_o}, exp_q[0]);
            check("cnt", cnt_o, m_cnt[cnt_sel_i]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        res_valid_i = 1'b1;
        rd_en_i = 1'b0;
        clear_i = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (n - 1) tick();
        check("rst_ready", res_ready_o, 0);
        check("rst_used", used_o, 0);
        for (int s = 0; s < 8; s++) begin
            cnt_sel_i = 3'(s);
            #1;
            check("rst_cnt", cnt_o, 0);
        end
        rst_i = 1'b0;
        res_valid_i = 1'b0;
    endtask

    task automatic push(input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [1:0] op,
                        input logic [2:0] rc, input bit clr, input bit pop_too);
        bit done;
        done = 1'b0;
        res_valid_i = 1'b1;
        res_key_i = k;
        res_value_i = v;
        res_opcode_i = op;
        res_rescode_i = rc;
        clear_i = clr;
        rd_en_i = pop_too;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = m_accept;
        end
        check("push_accepted", done, 1);
        res_valid_i = 1'b0;
        clear_i = 1'b0;
        rd_en_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int stalls = 0;
    logic [CW-1:0] exp_cnt [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset with valid held high
        do_reset(2);

        // single result
        push(32'h01000000, 16'h1234, 2'd1, 3'd2, 1'b0, 1'b0);
        check("single_valid", rd_valid_o, 1);
        check("single_key", rd_key_o, 32'h01000000);
        check("single_value", rd_value_o, 16'h1234);
        check("single_opcode", rd_opcode_o, 1);
        check("single_rescode", rd_rescode_o, 2);
        cnt_sel_i = 3'd2;
        #1;
        check("single_cnt2", cnt_o, 1);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        check("single_pop_used", used_o, 0);

        // fill, pop at full, then streaming push+pop across the pointer wrap
        do_reset(2);
        for (int i = 0; i < DEPTH; i++)
            push(32'hA000_0000 + 32'(i), 16'(i * 3), 2'(i), 3'(i % 7), 1'b0, 1'b0);
        check("fill_used", used_o, DEPTH);
        check("fill_ready", res_ready_o, 0);
        check("fill_head_key", rd_key_o, 32'hA000_0000);
        res_valid_i = 1'b1;
        res_key_i = 32'hB000_0000;
        rd_en_i = 1'b1;
        tick();
        check("full_pop_only", used_o, DEPTH - 1);
        check("full_pop_head", rd_key_o, 32'hA000_0001);
        for (int i = 1; i < 14; i++) begin
            res_key_i = 32'hB000_0000 + 32'(i);
            tick();
        end
        res_valid_i = 1'b0;
        repeat (DEPTH + 2) tick();
        rd_en_i = 1'b0;
        check("drain_used", used_o, 0);

        // counters and clear-with-accept
        do_reset(2);
        repeat (3) push($urandom, 16'($urandom), 2'd0, 3'd0, 1'b0, 1'b0);
        repeat (2) push($urandom, 16'($urandom), 2'd2, 3'd6, 1'b0, 1'b0);
        exp_cnt = '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0};
        check("model_cnt0", m_cnt[0], 3);
        for (int s = 0; s < 8; s++) begin
            cnt_sel_i = 3'(s);
            #1;
            check("cnt_tally", cnt_o, exp_cnt[s]);
        end
        push(32'hC0DE_0006, 16'h0006, 2'd2, 3'd6, 1'b1, 1'b0);
        check("model_cnt6_clr", m_cnt[6], 1);
        cnt_sel_i = 3'd6;
        #1;
        check("clr_cnt6", cnt_o, 1);
        cnt_sel_i = 3'd0;
        #1;
        check("clr_cnt0", cnt_o, 0);
        check("clr_fifo_kept", used_o, 6);

        // saturation at 4 bits
        do_reset(2);
        repeat (20) push($urandom, 16'($urandom), 2'd2, 3'd5, 1'b0, 1'b1);
        cnt_sel_i = 3'd5;
        #1;
        check("sat_cnt5", cnt_o, 4'hF);

        // randomized traffic; model compares every cycle
        do_reset(2);
        for (int c = 0; c < 1500; c++) begin
            res_valid_i   = (c < 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            res_key_i     = $urandom;
            res_value_i   = 16'($urandom);
            res_opcode_i  = 2'($urandom_range(0, 3));
            res_rescode_i = 3'($urandom_range(0, 7));
            rd_en_i       = (c < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            clear_i       = ($urandom_range(0, 63) == 0);
            cnt_sel_i     = 3'($urandom_range(0, 7));
            rst_i         = ($urandom_range(0, 499) == 0);
            tick();
            if (!rst_i && !res_ready_o && used_o != UW'(DEPTH)) stalls++;
        end
        rst_i = 1'b0;
        res_valid_i = 1'b0;
        clear_i = 1'b0;
        rd_en_i = 1'b1;
        repeat (DEPTH + 2) tick();
        rd_en_i = 1'b0;
        check("final_drain", used_o, 0);
`ifdef HT_RES_SINK_THROTTLE_EN
        check("throttle_stalls_seen", stalls > 0, 1);
`else
        check("no_stall_unless_full", stalls, 0);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
